// File: rtl/note_phase_counter.sv
// Phase source for the saw generator: advances phase once every cur_div enabled cycles.
// Divisor reloads and note-offs are deferred to the 255->0 wrap so the waveform stays continuous.
module note_phase_counter #(
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned PHASE_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   note_valid,
   output logic                   note_ready,
   input  logic [DIV_WIDTH-1:0]   note_div,
   output logic [PHASE_WIDTH-1:0] phase,
   output logic                   phase_step,
   output logic                   wrap,
   output logic                   busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   cur_div_q, cur_div_d;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]   pend_div_q, pend_div_d;
   logic                   pend_full_q, pend_full_d;
   logic [PHASE_WIDTH-1:0] phase_q, phase_d;
   logic                   step_q, step_d;
   logic                   wrap_q, wrap_d;
   logic                   accept;

   assign note_ready = !pend_full_q;
   assign accept     = note_valid && note_ready;
   assign phase      = phase_q;
   assign phase_step = step_q;
   assign wrap       = wrap_q;
   assign busy       = (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      cur_div_d   = cur_div_q;
      div_cnt_d   = div_cnt_q;
      pend_div_d  = pend_div_q;
      pend_full_d = pend_full_q;
      phase_d     = phase_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            phase_d   = '0;
            div_cnt_d = '0;
            // A zero offered while idle is simply consumed.
            if (accept && (note_div != '0)) begin
               cur_div_d = note_div;
               state_d   = StRun;
            end
         end
         StRun, StDrain: begin
            if (accept) begin
               pend_div_d  = note_div;
               pend_full_d = 1'b1;
               if (note_div == '0) begin
                  state_d = StDrain;
               end
            end
            if (enable) begin
               if (div_cnt_q == (cur_div_q - DIV_WIDTH'(1))) begin
                  div_cnt_d = '0;
                  phase_d   = phase_q + PHASE_WIDTH'(1);
                  step_d    = 1'b1;
                  if (phase_q == '1) begin
                     wrap_d = 1'b1;
                     // Only a value already held in the slot applies at this wrap.
                     if (pend_full_q) begin
                        pend_full_d = 1'b0;
                        if (pend_div_q != '0) begin
                           cur_div_d = pend_div_q;
                        end else begin
                           cur_div_d = '0;
                           state_d   = StIdle;
                        end
                     end
                  end
               end else begin
                  div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_div_q   <= '0;
         div_cnt_q   <= '0;
         pend_div_q  <= '0;
         pend_full_q <= 1'b0;
         phase_q     <= '0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_div_q   <= cur_div_d;
         div_cnt_q   <= div_cnt_d;
         pend_div_q  <= pend_div_d;
         pend_full_q <= pend_full_d;
         phase_q     <= phase_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
      end
   end

endmodule

// File: tb/tb_note_phase_counter.sv
// Self-checking bench for note_phase_counter: directed scenarios plus random stimulus
// compared every cycle against a countdown-style reference model.
module tb_note_phase_counter;

   localparam int DW = 16;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          note_valid = 1'b0;
   logic [DW-1:0] note_div = '0;
   logic          note_ready;
   logic [PW-1:0] phase;
   logic          phase_step;
   logic          wrap;
   logic          busy;

   note_phase_counter #(
      .DIV_WIDTH  (DW),
      .PHASE_WIDTH(PW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .note_valid(note_valid),
      .note_ready(note_ready),
      .note_div  (note_div),
      .phase     (phase),
      .phase_step(phase_step),
      .wrap      (wrap),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: cycles left until the next step, plus a queue for the pending slot.
   bit m_busy;
   int m_div;
   int m_left;
   int m_phase;
   int m_pend[$];
   bit m_step;
   bit m_wrap;

   function automatic void model_reset();
      m_busy  = 0;
      m_div   = 0;
      m_left  = 0;
      m_phase = 0;
      m_step  = 0;
      m_wrap  = 0;
      m_pend.delete();
   endfunction

   function automatic void model_edge(input bit v, input int d, input bit en);
      bit acc;
      bit had_pend;
      int pv;
      acc      = v && (m_pend.size() == 0);
      m_step   = 0;
      m_wrap   = 0;
      if (!m_busy) begin
         if (acc && d != 0) begin
            m_busy = 1;
            m_div  = d;
            m_left = d;
         end
      end else begin
         had_pend = (m_pend.size() != 0);
         pv       = had_pend ? m_pend[0] : 0;
         if (en) begin
            m_left--;
            if (m_left == 0) begin
               m_step  = 1;
               m_phase = (m_phase + 1) % 256;
               m_left  = m_div;
               if (m_phase == 0) begin
                  m_wrap = 1;
                  if (had_pend) begin
                     void'(m_pend.pop_front());
                     if (pv != 0) begin
                        m_div  = pv;
                        m_left = pv;
                     end else begin
                        m_busy  = 0;
                        m_phase = 0;
                     end
                  end
               end
            end
         end
         if (acc) m_pend.push_back(d);
      end
   endfunction

   task automatic cyc(input bit v, input int d, input bit en);
      note_valid = v;
      note_div   = DW'(d);
      enable     = en;
      @(posedge clk);
      model_edge(v, d, en);
      #1;
      check_eq("phase", phase, m_phase);
      check_eq("phase_step", phase_step, m_step);
      check_eq("wrap", wrap, m_wrap);
      check_eq("busy", busy, m_busy);
      check_eq("note_ready", note_ready, (m_pend.size() == 0));
   endtask

   // Asserts reset between edges and checks the reset values before any clock edge.
   task automatic do_reset();
      note_valid = 1'b0;
      rst_n      = 1'b0;
      #2;
      check_eq("rst_phase", phase, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", note_ready, 1);
      check_eq("rst_step", phase_step, 0);
      check_eq("rst_wrap", wrap, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_phase(input int p, input string tag);
      int n;
      n = 0;
      while (phase != PW'(p) && n < 4000) begin
         cyc(0, 0, 1);
         n++;
      end
      check_eq(tag, phase, p);
   endtask

   initial begin
      int since;
      int gap_before;
      int gap_after;
      int n;
      int cnt;
      bit seen;
      bit v;
      bit en;
      int d;
      int r;

      #1;
      do_reset();

      // Divisor 4 from cycle 0: phase 255 at cycle 1020, wrap at 1024.
      cyc(1, 4, 1);
      repeat (1020) cyc(0, 0, 1);
      check_eq("tp1_phase255", phase, 255);
      repeat (4) cyc(0, 0, 1);
      check_eq("tp1_wrap_phase", phase, 0);
      check_eq("tp1_wrap", wrap, 1);

      // Divisor 1: a step every cycle, two wraps in 512 cycles.
      do_reset();
      cyc(1, 1, 1);
      cnt = 0;
      n   = 0;
      repeat (512) begin
         cyc(0, 0, 1);
         if (wrap) cnt++;
         if (phase_step) n++;
      end
      check_eq("tp2_wraps", cnt, 2);
      check_eq("tp2_steps", n, 512);
      check_eq("tp2_phase", phase, 0);

      // Divisor 2 -> 3 deferred to the wrap.
      do_reset();
      cyc(1, 2, 1);
      run_to_phase(100, "tp3_reach100");
      cyc(1, 3, 1);
      check_eq("tp3_ready_low", note_ready, 0);
      since      = 0;
      gap_before = -1;
      gap_after  = -1;
      seen       = 0;
      for (int i = 0; i < 2000 && gap_after < 0; i++) begin
         cyc(0, 0, 1);
         since++;
         if (phase_step) begin
            if (seen) gap_after = since;
            else if (wrap) begin
               gap_before = since;
               seen       = 1;
            end
            since = 0;
         end
      end
      check_eq("tp3_gap_at_wrap", gap_before, 2);
      check_eq("tp3_gap_after", gap_after, 3);
      check_eq("tp3_ready_high", note_ready, 1);

      // Note-off at phase 50 drains to the wrap.
      do_reset();
      cyc(1, 2, 1);
      run_to_phase(50, "tp4_reach50");
      cyc(1, 0, 1);
      check_eq("tp4_busy_drain", busy, 1);
      n = 0;
      while (!wrap && n < 2000) begin
         cyc(0, 0, 1);
         n++;
      end
      check_eq("tp4_wrap_seen", wrap, 1);
      check_eq("tp4_busy_off", busy, 0);
      check_eq("tp4_phase0", phase, 0);
      cnt = 0;
      repeat (20) begin
         cyc(0, 0, 1);
         if (phase_step) cnt++;
      end
      check_eq("tp4_no_steps", cnt, 0);

      // Divisor 5 frozen mid-count for 10 cycles.
      do_reset();
      cyc(1, 5, 1);
      run_to_phase(3, "tp5_reach3");
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      cnt = 0;
      repeat (10) begin
         cyc(0, 0, 0);
         if (phase_step) cnt++;
      end
      check_eq("tp5_frozen_phase", phase, 3);
      check_eq("tp5_frozen_steps", cnt, 0);
      n = 0;
      while (!phase_step && n < 50) begin
         cyc(0, 0, 1);
         n++;
      end
      check_eq("tp5_remaining", n, 3);
      check_eq("tp5_phase4", phase, 4);

      // Asynchronous reset at phase 77 with a pending divisor.
      do_reset();
      cyc(1, 2, 1);
      run_to_phase(77, "tp6_reach77");
      cyc(1, 9, 1);
      check_eq("tp6_pending", note_ready, 0);
      do_reset();
      repeat (20) cyc(0, 0, 1);
      check_eq("tp6_idle_busy", busy, 0);
      check_eq("tp6_idle_phase", phase, 0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         v  = ($urandom_range(0, 3) == 0);
         r  = $urandom_range(0, 9);
         d  = (r == 0) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 20);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 4999) == 0) do_reset();
         cyc(v, d, en);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
